// File: rtl/wiener_block_stats.sv
// wiener_block_stats: per-block mean/variance engine with pixel replay aligned to the statistics.
// Optional WIENER_STATS_ROUND_EN rounds the mean half up instead of flooring it.
module wiener_block_stats #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_of_frame,
  input  logic                    end_of_frame,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    start_data,
  input  logic [31:0]             blocks_per_frame,
  output logic [2*DATA_WIDTH-1:0] mean_out,
  output logic [2*DATA_WIDTH-1:0] block_variance,
  output logic                    variance_ready,
  output logic [DATA_WIDTH-1:0]   data_out
);
  localparam int L  = $clog2(TOTAL_SAMPLES);
  localparam int SW = DATA_WIDTH + L;
  localparam int QW = 2 * DATA_WIDTH + L;
  localparam int DW = 2 * DATA_WIDTH + 2 * L;
  localparam int MW = 2 * DATA_WIDTH;
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [2*TOTAL_SAMPLES];
  logic [L-1:0] cnt, rp_idx;
  logic [SW-1:0] sum, s_r, mean_c;
  logic [QW-1:0] sq, q_r;
  logic [DW-1:0] diff;
  logic [MW-1:0] sqr, m_r, v_r;
  logic [31:0] blk_cnt, blk_nx;
  logic wr_half, rd1, rd2, rp_half, rp_on, v1, v2, pend, p_sof, p_eof, eof_r;
  logic last, take, sof_t, eof_t, close;

  assign sqr = MW'(data_in) * MW'(data_in);
`ifdef WIENER_STATS_ROUND_EN
  assign mean_c = s_r + SW'(TOTAL_SAMPLES / 2);
`else
  assign mean_c = s_r;
`endif

  // A start pulse on the final sample edge is deferred one cycle via pend.
  always_comb begin
    last     = state == ACC && cnt == L'(TOTAL_SAMPLES - 1);
    take     = pend || (start_data && !last);
    sof_t    = pend ? p_sof : start_of_frame;
    eof_t    = pend ? p_eof : end_of_frame;
    blk_nx   = blk_cnt + 32'd1;
    close    = eof_r || blk_nx == blocks_per_frame;
    state_nx = take ? ACC : last ? IDLE : state;
    diff     = {q_r, {L{1'b0}}} - DW'(s_r) * DW'(s_r);
  end

  always_ff @(posedge clk) begin
    if (take || state == ACC) mem[{wr_half, take ? L'(0) : cnt}] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sum     <= '0;
      sq      <= '0;
      s_r     <= '0;
      q_r     <= '0;
      wr_half <= 1'b0;
      rd1     <= 1'b0;
      pend    <= 1'b0;
      p_sof   <= 1'b0;
      p_eof   <= 1'b0;
      eof_r   <= 1'b0;
      blk_cnt <= '0;
      v1      <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= start_data && last;
      p_sof <= start_of_frame;
      p_eof <= end_of_frame;
      v1    <= last;
      if (take) begin
        cnt   <= L'(1);
        sum   <= SW'(data_in);
        sq    <= QW'(sqr);
        eof_r <= eof_t;
        if (sof_t) blk_cnt <= '0;
      end else if (state == ACC) begin
        cnt <= cnt + L'(1);
        sum <= sum + SW'(data_in);
        sq  <= sq + QW'(sqr);
      end
      if (last) begin
        s_r     <= sum + SW'(data_in);
        q_r     <= sq + QW'(sqr);
        rd1     <= wr_half;
        wr_half <= ~wr_half;
        blk_cnt <= close ? '0 : blk_nx;
      end
    end
  end

  // Two-cycle CALC pipeline, then strobe and replay from the finished half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2             <= 1'b0;
      m_r            <= '0;
      v_r            <= '0;
      rd2            <= 1'b0;
      mean_out       <= '0;
      block_variance <= '0;
      variance_ready <= 1'b0;
      data_out       <= '0;
      rp_on          <= 1'b0;
      rp_idx         <= '0;
      rp_half        <= 1'b0;
    end else begin
      v2             <= v1;
      variance_ready <= v2;
      if (v1) begin
        m_r <= MW'(mean_c >> L);
        v_r <= MW'(diff >> (2 * L));
        rd2 <= rd1;
      end
      if (v2) begin
        mean_out       <= m_r;
        block_variance <= v_r;
        data_out       <= mem[{rd2, L'(0)}];
        rp_half        <= rd2;
        rp_idx         <= L'(1);
        rp_on          <= 1'b1;
      end else if (rp_on) begin
        data_out <= mem[{rp_half, rp_idx}];
        rp_idx   <= rp_idx + L'(1);
        rp_on    <= rp_idx != L'(TOTAL_SAMPLES - 1);
      end else begin
        data_out <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wiener_block_stats.sv
// tb_wiener_block_stats: directed table-driven bench for wiener_block_stats (N=8, 8-bit pixels).
module tb_wiener_block_stats;
  typedef logic [0:7][7:0] blk_t;
  typedef struct {blk_t px; int len; bit s; bit f; int gap; int m; int v;} vec_t;
  typedef struct {blk_t px; int m; int v; int e;} exp_t;
`ifdef WIENER_STATS_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic clk = 0, rst_n = 0, sof = 0, eof = 0, start_data = 0;
  logic [7:0] data_in = 0;
  logic [31:0] bpf = 32'd8;
  logic [15:0] mean_out, block_variance;
  logic variance_ready;
  logic [7:0] data_out;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q[$];
  vec_t tbl[7];

  wiener_block_stats #(.DATA_WIDTH(8), .TOTAL_SAMPLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_of_frame(sof), .end_of_frame(eof),
    .data_in(data_in), .start_data(start_data), .blocks_per_frame(bpf),
    .mean_out(mean_out), .block_variance(block_variance),
    .variance_ready(variance_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at cyc %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input blk_t px, input int m, input int v);
    exp_t e;
    e.px = px;
    e.m = m;
    e.v = v;
    e.e = cyc;
    q.push_back(e);
  endtask

  task automatic send(input blk_t px, input int len, input bit s, input bit f, input int gap, input int m, input int v);
    for (int i = 0; i < len; i++) begin
      start_data = (i == 0);
      sof = s;
      eof = f;
      data_in = px[i];
      @(posedge clk);
      #1;
    end
    if (len == 8) push(px, m, v);
    start_data = 0;
    sof = 0;
    eof = 0;
    repeat (gap) begin
      data_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (variance_ready) begin
        if (q.size() == 0) chk("unexpected_strobe", variance_ready, 0);
        else begin
          me = q.pop_front();
          chk("latency", cyc, me.e + 2);
          chk("mean", mean_out, me.m);
          chk("variance", block_variance, me.v);
          chk("replay0", data_out, me.px[0]);
          for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("replay", data_out, me.px[k]);
            chk("strobe_width", variance_ready, 0);
          end
        end
      end else chk("idle_zero", data_out, 0);
    end
  end

  initial begin
    blk_t b, v1b, cb;
    int a, c;
    v1b = '{8'd203, 8'd222, 8'd235, 8'd123, 8'd69, 8'd73, 8'd202, 8'd162};
    cb = '{default: 8'd100};
    tbl[0] = '{v1b, 8, 1'b1, 1'b0, 3, 161, 3786};
    tbl[1] = '{cb, 8, 1'b0, 1'b0, 2, 100, 0};
    tbl[2] = '{'{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255}, 8, 1'b0, 1'b0, 0, RND ? 128 : 127, 16256};
    tbl[3] = '{v1b, 8, 1'b0, 1'b0, 0, 161, 3786};
    tbl[4] = '{cb, 8, 1'b0, 1'b0, 0, 100, 0};
    tbl[5] = '{v1b, 3, 1'b0, 1'b0, 0, 0, 0};
    tbl[6] = '{v1b, 8, 1'b0, 1'b1, 6, 161, 3786};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mean", mean_out, 0);
    chk("rst_var", block_variance, 0);
    chk("rst_ready", variance_ready, 0);
    chk("rst_data", data_out, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send(tbl[i].px, tbl[i].len, tbl[i].s, tbl[i].f, tbl[i].gap, tbl[i].m, tbl[i].v);
    // frame of 8 two-level blocks: mean (a+b)/2, variance (b-a)^2/4
    for (int k = 0; k < 8; k++) begin
      a = 20 * k + 5;
      c = a + 3 + 3 * (k % 2);
      for (int j = 0; j < 8; j++) b[j] = 8'(j < 4 ? a : c);
      send(b, 8, k == 0, k == 7, 4, RND ? (a + c + 1) / 2 : (a + c) / 2, (c - a) * (c - a) / 4);
    end
    // start pulse coinciding with the final sample: next block begins one edge later
    for (int i = 0; i < 8; i++) begin
      start_data = (i == 0 || i == 7);
      data_in = v1b[i];
      @(posedge clk);
      #1;
    end
    push(v1b, 161, 3786);
    start_data = 0;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'd100;
      @(posedge clk);
      #1;
    end
    push(cb, 100, 0);
    repeat (14) @(posedge clk);
    #1;
    send(v1b, 5, 1'b0, 1'b0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_mean", mean_out, 0);
    chk("mid_rst_var", block_variance, 0);
    chk("mid_rst_data", data_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_mean", mean_out, 0);
    chk("post_rst_var", block_variance, 0);
    send(cb, 8, 1'b1, 1'b0, 14, 100, 0);
    repeat (4) @(posedge clk);
    chk("pending_blocks", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
